// File: rtl/alu_sequencer.sv
// alu_sequencer: FETCH/DECODE/EXEC/WB control sequencer for an
// accumulator datapath with an external ALU and register file.
//
// Optional feature macro: ALU_SEQ_BRANCH_EN
//   defined   -> JZ/JC/JMP load pc with the zero-extended operand when taken
//   undefined -> JZ/JC/JMP behave as NOP (pc+1, no other effect)
//
// Parameters:
//   PC_WIDTH       program counter width (default 8)
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   instr_req      fetch request (high in FETCH only)
//   instr_valid    instr_data valid, sampled while instr_req=1
//   instr_data     [7:4] opcode, [3:0] operand
//   pc             program counter
//   alu_select     ALU op select (opcode in EXEC/WB of ALU ops, else 0)
//   alu_zero_flag  ALU zero result
//   alu_carry_out  ALU carry/borrow
//   acc_load       one-cycle ACC load strobe
//   acc_src        ACC mux select: 0 ALU, 1 register file
//   reg_addr       register-file address (latched operand)
//   reg_wr         one-cycle register-file write strobe
//   zero_flag      latched ALU zero status
//   carry_flag     latched ALU carry status
//   halted         high in HALT

module alu_sequencer #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                instr_req,
    input  logic                instr_valid,
    input  logic [7:0]          instr_data,
    output logic [PC_WIDTH-1:0] pc,
    output logic [3:0]          alu_select,
    input  logic                alu_zero_flag,
    input  logic                alu_carry_out,
    output logic                acc_load,
    output logic                acc_src,
    output logic [3:0]          reg_addr,
    output logic                reg_wr,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_NOR  = 4'h3,
        OP_LDA  = 4'h4,
        OP_STA  = 4'h5,
        OP_JZ   = 4'h6,
        OP_JC   = 4'h7,
        OP_JMP  = 4'h8,
        OP_SHFR = 4'hB,
        OP_SHFL = 4'hC,
        OP_HALT = 4'hF
    } op_e;

    state_e              state_q, state_d;
    logic [7:0]          ir_q, ir_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;

    op_e                 op;
    logic                is_alu;
    logic                br_taken;

    // Undefined opcodes cast to values outside the named set and
    // fall through every decoder as NOP.
    assign op = op_e'(ir_q[7:4]);

    always_comb begin
        is_alu = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_SHFR, OP_SHFL: is_alu = 1'b1;
            default:                                  is_alu = 1'b0;
        endcase
    end

    // Conditions use the flags latched by earlier ALU ops.
    always_comb begin
        br_taken = 1'b0;
`ifdef ALU_SEQ_BRANCH_EN
        case (op)
            OP_JMP:  br_taken = 1'b1;
            OP_JZ:   br_taken = zero_q;
            OP_JC:   br_taken = carry_q;
            default: br_taken = 1'b0;
        endcase
`else
        br_taken = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        instr_req  = 1'b0;
        halted     = 1'b0;
        alu_select = OP_NOP;
        acc_load   = 1'b0;
        acc_src    = 1'b0;
        reg_wr     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr_data;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_alu)
                    state_d = S_EXEC;
                else if (op == OP_HALT)
                    state_d = S_HALT;
                else
                    state_d = S_WB;
            end

            // Select is presented a full cycle before the result is
            // captured so the ALU can settle.
            S_EXEC: begin
                alu_select = ir_q[7:4];
                state_d    = S_WB;
            end

            S_WB: begin
                state_d = S_FETCH;
                if (br_taken)
                    pc_d = PC_WIDTH'(ir_q[3:0]);
                else
                    pc_d = pc_q + 1'b1;

                if (is_alu) begin
                    alu_select = ir_q[7:4];
                    acc_load   = 1'b1;
                    zero_d     = alu_zero_flag;
                    carry_d    = alu_carry_out;
                end else if (op == OP_LDA) begin
                    acc_load = 1'b1;
                    acc_src  = 1'b1;
                end else if (op == OP_STA) begin
                    reg_wr = 1'b1;
                end
            end

            // Only reset leaves HALT.
            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= 8'h00;
            pc_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign pc         = pc_q;
    assign reg_addr   = ir_q[3:0];
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus hand-written
// sequences for idle fetch, pc wrap, reset mid-instruction and HALT.

module tb_alu_sequencer;

`ifdef ALU_SEQ_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       instr_req;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [7:0] pc;
    logic [3:0] alu_select;
    logic       alu_zero_flag;
    logic       alu_carry_out;
    logic       acc_load;
    logic       acc_src;
    logic [3:0] reg_addr;
    logic       reg_wr;
    logic       zero_flag;
    logic       carry_flag;
    logic       halted;

    alu_sequencer #(.PC_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_req     (instr_req),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .pc            (pc),
        .alu_select    (alu_select),
        .alu_zero_flag (alu_zero_flag),
        .alu_carry_out (alu_carry_out),
        .acc_load      (acc_load),
        .acc_src       (acc_src),
        .reg_addr      (reg_addr),
        .reg_wr        (reg_wr),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic       c;
        logic [7:0] pc;
        logic       fz;
        logic       fc;
        int         ld;
        int         wr;
        logic       src;
        logic [3:0] sel;
        int         done;
        logic [3:0] wa;
    } vec_t;

    vec_t vecs[13];

    // Observations from one instruction, cycle k counted from accept.
    int         o_ld, o_wr, o_done;
    logic       o_src, o_both, o_to;
    logic [3:0] o_s1, o_s2, o_s3, o_wa;

    task automatic wait_fetch();
        int w = 0;
        while (!instr_req && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!instr_req)
            check("fetch_wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_instr(input logic [7:0] d, input logic z,
                             input logic c);
        o_ld = 0; o_wr = 0; o_done = 0;
        o_src = 1'b0; o_both = 1'b0; o_to = 1'b0;
        o_s1 = 4'h0; o_s2 = 4'h0; o_s3 = 4'h0; o_wa = 4'h0;
        wait_fetch();
        instr_valid   = 1'b1;
        instr_data    = d;
        alu_zero_flag = z;
        alu_carry_out = c;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (acc_load) begin
                o_ld  = k;
                o_src = acc_src;
            end
            if (reg_wr) begin
                o_wr = k;
                o_wa = reg_addr;
            end
            if (acc_load && reg_wr) o_both = 1'b1;
            if (k == 1) o_s1 = alu_select;
            if (k == 2) o_s2 = alu_select;
            if (k == 3) o_s3 = alu_select;
            if (k >= 2 && instr_req) begin
                o_done = k;
                break;
            end
            @(posedge clk); #1;
        end
        if (o_done == 0) o_to = 1'b1;
    endtask

    task automatic idle_check(input int cycles);
        logic [7:0] pc0;
        logic       z0, c0;
        int         bad = 0;
        pc0 = pc;
        z0  = zero_flag;
        c0  = carry_flag;
        instr_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (!instr_req || acc_load || reg_wr || halted ||
                pc !== pc0 || alu_select !== 4'h0 ||
                zero_flag !== z0 || carry_flag !== c0)
                bad++;
        end
        check("idle_fetch_bad_cycles", bad, 0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_data    = 8'h00;
        alu_zero_flag = 1'b0;
        alu_carry_out = 1'b0;

        //        d     z  c  pc             fz fc ld wr src sel  done wa
        vecs[0]  = '{8'h13, 1, 1, 8'd1,             1, 1, 3, 0, 0, 4'h1, 4, 4'h0};
        vecs[1]  = '{8'h65, 0, 0, BR ? 8'd5  : 8'd2,  1, 1, 0, 0, 0, 4'h0, 3, 4'h0};
        vecs[2]  = '{8'h52, 0, 0, BR ? 8'd6  : 8'd3,  1, 1, 0, 2, 0, 4'h0, 3, 4'h2};
        vecs[3]  = '{8'h21, 0, 0, BR ? 8'd7  : 8'd4,  0, 0, 3, 0, 0, 4'h2, 4, 4'h0};
        vecs[4]  = '{8'h79, 1, 1, BR ? 8'd8  : 8'd5,  0, 0, 0, 0, 0, 4'h0, 3, 4'h0};
        vecs[5]  = '{8'h47, 1, 1, BR ? 8'd9  : 8'd6,  0, 0, 2, 0, 1, 4'h0, 3, 4'h0};
        vecs[6]  = '{8'hA3, 1, 1, BR ? 8'd10 : 8'd7,  0, 0, 0, 0, 0, 4'h0, 3, 4'h0};
        vecs[7]  = '{8'h30, 1, 0, BR ? 8'd11 : 8'd8,  1, 0, 3, 0, 0, 4'h3, 4, 4'h0};
        vecs[8]  = '{8'h8C, 0, 0, BR ? 8'd12 : 8'd9,  1, 0, 0, 0, 0, 4'h0, 3, 4'h0};
        vecs[9]  = '{8'hB0, 0, 1, BR ? 8'd13 : 8'd10, 0, 1, 3, 0, 0, 4'hB, 4, 4'h0};
        vecs[10] = '{8'hC0, 1, 1, BR ? 8'd14 : 8'd11, 1, 1, 3, 0, 0, 4'hC, 4, 4'h0};
        vecs[11] = '{8'h7E, 0, 0, BR ? 8'd14 : 8'd12, 1, 1, 0, 0, 0, 4'h0, 3, 4'h0};
        vecs[12] = '{8'h00, 0, 0, BR ? 8'd15 : 8'd13, 1, 1, 0, 0, 0, 4'h0, 3, 4'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_zero", zero_flag, 0);
        check("rst_carry", carry_flag, 0);
        check("rst_acc_load", acc_load, 0);
        check("rst_acc_src", acc_src, 0);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_alu_select", alu_select, 0);
        check("rst_halted", halted, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_instr_req", instr_req, 1);

        // Vector table
        for (int i = 0; i < 13; i++) begin
            if (i == 2) idle_check(10);
            run_instr(vecs[i].d, vecs[i].z, vecs[i].c);
            check($sformatf("v%0d_timeout", i), o_to, 0);
            check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d_zero", i), zero_flag, vecs[i].fz);
            check($sformatf("v%0d_carry", i), carry_flag, vecs[i].fc);
            check($sformatf("v%0d_load_cyc", i), o_ld, vecs[i].ld);
            check($sformatf("v%0d_wr_cyc", i), o_wr, vecs[i].wr);
            check($sformatf("v%0d_acc_src", i), o_src, vecs[i].src);
            check($sformatf("v%0d_sel_decode", i), o_s1, 4'h0);
            check($sformatf("v%0d_sel_exec", i), o_s2, vecs[i].sel);
            check($sformatf("v%0d_sel_wb", i), o_s3, vecs[i].sel);
            check($sformatf("v%0d_done_cyc", i), o_done, vecs[i].done);
            check($sformatf("v%0d_wr_addr", i), o_wa, vecs[i].wa);
            check($sformatf("v%0d_load_and_wr", i), o_both, 0);
        end

        // pc wrap from 255 with an undefined opcode (NOP behaviour)
        begin
            int n = 0;
            while (pc != 8'hFF && n < 300) begin
                run_instr(8'h00, 1'b0, 1'b0);
                n++;
            end
        end
        check("wrap_reach_255", pc, 8'hFF);
        run_instr(8'hA5, 1'b0, 1'b0);
        check("wrap_pc", pc, 8'h00);
        check("wrap_zero", zero_flag, 1);
        check("wrap_carry", carry_flag, 1);
        check("wrap_load", o_ld, 0);
        check("wrap_wr", o_wr, 0);
        run_instr(8'h00, 1'b0, 1'b0);
        check("post_wrap_pc", pc, 8'h01);

        // Reset pulse during EXEC of SUB
        wait_fetch();
        instr_valid   = 1'b1;
        instr_data    = 8'h2F;
        alu_zero_flag = 1'b0;
        alu_carry_out = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_sub_exec_sel", alu_select, 4'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", pc, 0);
        check("mid_rst_zero", zero_flag, 0);
        check("mid_rst_carry", carry_flag, 0);
        check("mid_rst_alu_select", alu_select, 0);
        check("mid_rst_reg_addr", reg_addr, 0);
        check("mid_rst_halted", halted, 0);
        begin
            int strobes = 0;
            for (int i = 0; i < 3; i++) begin
                if (acc_load || reg_wr || acc_src) strobes++;
                @(posedge clk); #1;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (acc_load || reg_wr || acc_src) strobes++;
            end
            check("mid_rst_strobes", strobes, 0);
        end
        check("mid_rst_after_pc", pc, 0);
        check("mid_rst_after_req", instr_req, 1);
        check("mid_rst_after_zero", zero_flag, 0);

        // HALT
        run_instr(8'h00, 1'b0, 1'b0);
        check("pre_halt_pc", pc, 8'h01);
        wait_fetch();
        instr_valid = 1'b1;
        instr_data  = 8'hF0;
        @(posedge clk); #1;
        instr_data = 8'h13;
        @(posedge clk); #1;
        begin
            int bad_h = 0, bad_r = 0, bad_s = 0, bad_p = 0;
            for (int i = 0; i < 20; i++) begin
                if (halted !== 1'b1) bad_h++;
                if (instr_req !== 1'b0) bad_r++;
                if (acc_load || reg_wr || alu_select != 4'h0) bad_s++;
                if (pc !== 8'h01) bad_p++;
                @(posedge clk); #1;
            end
            check("halt_halted_bad", bad_h, 0);
            check("halt_req_bad", bad_r, 0);
            check("halt_strobe_bad", bad_s, 0);
            check("halt_pc_bad", bad_p, 0);
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("halt_exit_reset", halted, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("halt_exit_req", instr_req, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
